// File: rtl/mult_pkg.sv
// Shared types, defaults and the round-robin pick function for the
// shared shift-add multiplier scheduler.
package mult_pkg;

   localparam int unsigned DefaultNreq  = 4;
   localparam int unsigned DefaultWidth = 4;
   localparam int unsigned MaxNreq      = 32;
   localparam int unsigned MaxIdW       = 5;
   localparam int unsigned StateW       = 2;

   typedef enum logic [StateW-1:0] {
      StIdle,
      StCompute,
      StResp
   } state_e;

   // First valid index scanning last+1, last+2, ... with wrap. The scan runs from
   // the farthest offset down so the nearest valid requester overwrites the result.
   function automatic int unsigned rr_pick(input logic [MaxNreq-1:0] valid,
                                           input int unsigned        last,
                                           input int unsigned        nreq);
      int unsigned idx;
      rr_pick = last;
      for (int off = int'(nreq); off > 0; off--) begin
         idx = last + off;
         if (idx >= nreq) idx = idx - nreq;
         if (valid[idx[MaxIdW-1:0]]) rr_pick = idx;
      end
   endfunction

endpackage

// File: rtl/mult_shift_add_core.sv
// Iterative shift-add multiplier: one partial product per cycle for WIDTH cycles
// after start; done pulses on the cycle whose edge completes the last iteration.
module mult_shift_add_core
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               run_q, run_d;

   assign done    = run_q && (cnt_q == CntW'(WIDTH - 1));
   assign product = acc_q;

   // Multiplicand shifts left and multiplier shifts right, so bit k of b
   // meets a << k on iteration k.
   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      if (start) begin
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = '0;
         run_d    = 1'b1;
      end else if (run_q) begin
         if (mplier_q[0]) acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CntW'(1);
         if (done) run_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
      end
   end

endmodule

// File: rtl/mult_scheduler.sv
// Round-robin scheduler sharing one shift-add multiplier between NREQ
// requesters, returning tagged products on a single backpressured channel.
module mult_scheduler
   import mult_pkg::*;
#(
   parameter  int unsigned NREQ  = DefaultNreq,
   parameter  int unsigned WIDTH = DefaultWidth,
   localparam int unsigned IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic [2*WIDTH-1:0]    rsp_product,
   input  logic                  rsp_ready,
   output logic                  busy
);

   state_e             state_q, state_d;
   logic [IDW-1:0]     last_q, id_q, winner;
   logic               accept, core_done;
   logic [2*WIDTH-1:0] core_product;
   logic [WIDTH-1:0]   a_arr [NREQ];
   logic [WIDTH-1:0]   b_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
      assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
   end

   assign winner = IDW'(rr_pick(MaxNreq'(req_valid), 32'(last_q), NREQ));

   // Grant is gated by reset so req_ready reads zero while reset is held.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      req_ready = '0;
      unique case (state_q)
         StIdle: begin
            if (reset && |req_valid) begin
               accept            = 1'b1;
               req_ready[winner] = 1'b1;
               state_d           = StCompute;
            end
         end
         StCompute: if (core_done) state_d = StResp;
         StResp:    if (rsp_ready) state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         last_q  <= IDW'(NREQ - 1);
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            last_q <= winner;
            id_q   <= winner;
         end
      end
   end

   mult_shift_add_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk     (clk),
      .reset   (reset),
      .start   (accept),
      .a       (a_arr[winner]),
      .b       (b_arr[winner]),
      .done    (core_done),
      .product (core_product)
   );

   assign busy        = (state_q != StIdle);
   assign rsp_valid   = (state_q == StResp);
   assign rsp_id      = rsp_valid ? id_q : '0;
   assign rsp_product = rsp_valid ? core_product : '0;

endmodule

// File: tb/tb_mult_scheduler.sv
// Self-checking bench for mult_scheduler: directed vectors, hand-written
// protocol sequences and a randomized run against a behavioural model.
module tb_mult_scheduler;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [15:0] req_a, req_b;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_product;
   logic        rsp_ready;
   logic        busy;

   mult_scheduler #(
      .NREQ  (NREQ),
      .WIDTH (WIDTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_product (rsp_product),
      .rsp_ready   (rsp_ready),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int id;
      int a;
      int b;
      int prod;
   } vec_t;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   int op_a [4];
   int op_b [4];
   int grant_q [$];
   int gcyc_q  [$];
   int rid_q   [$];
   int rprod_q [$];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int oh_idx(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic int qget(input int q [$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   function automatic int model_pick(input logic [3:0] v, input int last);
      for (int off = 1; off <= NREQ; off++) begin
         if (v[(last + off) % NREQ]) return (last + off) % NREQ;
      end
      return -1;
   endfunction

   task automatic drive(input logic [3:0] v);
      req_valid = v;
      req_a = {4'(op_a[3]), 4'(op_a[2]), 4'(op_a[1]), 4'(op_a[0])};
      req_b = {4'(op_b[3]), 4'(op_b[2]), 4'(op_b[1]), 4'(op_b[0])};
   endtask

   task automatic clear_q();
      grant_q.delete();
      gcyc_q.delete();
      rid_q.delete();
      rprod_q.delete();
   endtask

   // Record what the DUT shows this cycle, then move to the next falling edge.
   task automatic step();
      #1;
      if (req_ready != 4'b0) begin
         grant_q.push_back(oh_idx(req_ready));
         gcyc_q.push_back(cyc);
      end
      if (rsp_valid && rsp_ready) begin
         rid_q.push_back(int'(rsp_id));
         rprod_q.push_back(int'(rsp_product));
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic apply_reset();
      reset     = 1'b0;
      rsp_ready = 1'b0;
      drive(4'hF);
      #1;
      check("rst_req_ready", int'(req_ready), 0);
      check("rst_rsp_valid", int'(rsp_valid), 0);
      check("rst_rsp_id", int'(rsp_id), 0);
      check("rst_rsp_product", int'(rsp_product), 0);
      check("rst_busy", int'(busy), 0);
      drive(4'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      int lat, bc, rc;
      logic [3:0] m;
      m = 4'b0001 << v.id;
      op_a[v.id] = v.a;
      op_b[v.id] = v.b;
      rsp_ready  = 1'b1;
      drive(m);
      #1 check("vec_grant", int'(req_ready), int'(m));
      step();
      drive(4'h0);
      lat = 0; bc = 0; rc = 0;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (busy) bc++;
         if (req_ready != 4'b0) rc++;
         if (rsp_valid) break;
         step();
         lat++;
      end
      check("vec_latency", lat, WIDTH);
      check("vec_product", int'(rsp_product), v.prod);
      check("vec_id", int'(rsp_id), v.id);
      check("vec_busy_cycles", bc, WIDTH + 1);
      check("vec_no_regrant", rc, 0);
      step();
      #1;
      check("vec_rsp_drop", int'(rsp_valid), 0);
      check("vec_busy_drop", int'(busy), 0);
   endtask

   initial begin
      vec_t vecs [6];
      int exp_g [5];
      int exp_p [4];
      // random-phase model state
      int m_last, m_phase, m_cnt, m_id, m_prod, w;
      int pv [4];
      int pa [4];
      int pb [4];
      logic [3:0] vmask, exp_rdy;

      vecs[0] = '{id: 0, a: 2,  b: 2,  prod: 4};
      vecs[1] = '{id: 2, a: 5,  b: 3,  prod: 15};
      vecs[2] = '{id: 2, a: 15, b: 15, prod: 225};
      vecs[3] = '{id: 2, a: 0,  b: 9,  prod: 0};
      vecs[4] = '{id: 1, a: 7,  b: 6,  prod: 42};
      vecs[5] = '{id: 3, a: 1,  b: 15, prod: 15};
      for (int i = 0; i < 4; i++) begin
         op_a[i] = 0;
         op_b[i] = 0;
      end

      @(negedge clk);
      apply_reset();

      // Directed single-requester vectors
      foreach (vecs[i]) run_vec(vecs[i]);

      // All requesters valid continuously: strict rotation from requester 0
      apply_reset();
      op_a = '{1, 2, 4, 7};
      op_b = '{1, 3, 4, 5};
      rsp_ready = 1'b1;
      clear_q();
      drive(4'hF);
      for (int k = 0; k < 60 && grant_q.size() < 5; k++) step();
      drive(4'h0);
      for (int k = 0; k < 20 && rid_q.size() < 5; k++) step();
      exp_g = '{0, 1, 2, 3, 0};
      exp_p = '{1, 6, 16, 35};
      for (int i = 0; i < 5; i++) check("rot_grant", qget(grant_q, i), exp_g[i]);
      for (int i = 0; i < 4; i++) begin
         check("rot_rsp_id", qget(rid_q, i), i);
         check("rot_rsp_product", qget(rprod_q, i), exp_p[i]);
      end
      check("rot_interval", qget(gcyc_q, 1) - qget(gcyc_q, 0), WIDTH + 2);

      // Backpressure in RESP with another requester waiting
      clear_q();
      op_a[3] = 9; op_b[3] = 9;
      op_a[2] = 2; op_b[2] = 3;
      rsp_ready = 1'b0;
      drive(4'b1000);
      step();
      drive(4'b0100);
      for (int k = 0; k < 20 && !rsp_valid; k++) step();
      for (int k = 0; k < 6; k++) begin
         #1;
         check("bp_valid", int'(rsp_valid), 1);
         check("bp_product", int'(rsp_product), 81);
         check("bp_id", int'(rsp_id), 3);
         check("bp_req_ready", int'(req_ready), 0);
         step();
      end
      rsp_ready = 1'b1;
      #1 check("bp_no_grant_at_hs", int'(req_ready), 0);
      step();
      #1;
      check("bp_rsp_drop", int'(rsp_valid), 0);
      check("bp_next_grant", int'(req_ready), 4'b0100);
      step();
      drive(4'h0);
      for (int k = 0; k < 20 && rid_q.size() < 2; k++) step();
      check("bp_count", rid_q.size(), 2);
      check("bp_first_product", qget(rprod_q, 0), 81);
      check("bp_second_id", qget(rid_q, 1), 2);
      check("bp_second_product", qget(rprod_q, 1), 6);

      // Reset in the middle of COMPUTE discards the operation
      clear_q();
      op_a[0] = 3; op_b[0] = 3;
      op_a[3] = 2; op_b[3] = 2;
      rsp_ready = 1'b1;
      drive(4'b0001);
      step();
      step();
      #1 check("mid_busy_before", int'(busy), 1);
      #1 reset = 1'b0;
      #1;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_rsp_valid", int'(rsp_valid), 0);
      check("mid_rst_req_ready", int'(req_ready), 0);
      @(negedge clk);
      cyc++;
      clear_q();
      drive(4'b1001);
      reset = 1'b1;
      #1 check("mid_prio_after_rst", int'(req_ready), 4'b0001);
      step();
      drive(4'b1000);
      for (int k = 0; k < 30 && rid_q.size() < 2; k++) step();
      drive(4'h0);
      for (int k = 0; k < 8; k++) step();
      check("mid_rsp_count", rid_q.size(), 2);
      check("mid_first_id", qget(rid_q, 0), 0);
      check("mid_first_product", qget(rprod_q, 0), 9);
      check("mid_second_id", qget(rid_q, 1), 3);
      check("mid_second_product", qget(rprod_q, 1), 4);

      // Lone last-granted requester is regranted; a withdrawn requester is skipped
      clear_q();
      op_a[1] = 6; op_b[1] = 7;
      op_a[2] = 5; op_b[2] = 5;
      drive(4'b0010);
      for (int k = 0; k < 10 && grant_q.size() < 1; k++) step();
      drive(4'b0110);
      step();
      step();
      drive(4'b0010);
      for (int k = 0; k < 30 && grant_q.size() < 2; k++) step();
      drive(4'b0000);
      for (int k = 0; k < 20 && rid_q.size() < 2; k++) step();
      for (int k = 0; k < 8; k++) step();
      check("regrant_count", grant_q.size(), 2);
      check("regrant_first", qget(grant_q, 0), 1);
      check("regrant_second", qget(grant_q, 1), 1);
      check("regrant_interval", qget(gcyc_q, 1) - qget(gcyc_q, 0), WIDTH + 2);
      check("regrant_product", qget(rprod_q, 1), 42);

      // Randomized traffic against a transaction-level model
      apply_reset();
      m_last = NREQ - 1;
      m_phase = 0; m_cnt = 0; m_id = 0; m_prod = 0;
      for (int i = 0; i < 4; i++) begin
         pv[i] = 0; pa[i] = 0; pb[i] = 0;
      end
      for (int t = 0; t < 400; t++) begin
         for (int i = 0; i < 4; i++) begin
            if (pv[i] == 0 && $urandom_range(0, 2) == 0) begin
               pv[i] = 1;
               pa[i] = int'($urandom_range(0, 15));
               pb[i] = int'($urandom_range(0, 15));
            end
            op_a[i] = pa[i];
            op_b[i] = pb[i];
            vmask[i] = (pv[i] != 0);
         end
         drive(vmask);
         rsp_ready = ($urandom_range(0, 2) != 0);
         exp_rdy = 4'b0;
         w = -1;
         if (m_phase == 0) begin
            w = model_pick(vmask, m_last);
            if (w >= 0) exp_rdy[w] = 1'b1;
         end
         #1;
         check("rnd_req_ready", int'(req_ready), int'(exp_rdy));
         check("rnd_rsp_valid", int'(rsp_valid), (m_phase == 2) ? 1 : 0);
         check("rnd_busy", int'(busy), (m_phase != 0) ? 1 : 0);
         if (m_phase == 2) begin
            check("rnd_rsp_id", int'(rsp_id), m_id);
            check("rnd_rsp_product", int'(rsp_product), m_prod);
         end
         if (m_phase == 0 && w >= 0) begin
            m_phase = 1;
            m_cnt   = WIDTH;
            m_id    = w;
            m_prod  = pa[w] * pb[w];
            m_last  = w;
            pv[w]   = 0;
         end else if (m_phase == 1) begin
            m_cnt--;
            if (m_cnt == 0) m_phase = 2;
         end else if (m_phase == 2 && rsp_ready) begin
            m_phase = 0;
         end
         @(negedge clk);
         cyc++;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mult_scheduler.md
Name: mult_scheduler

Overview:
Shares one shift-add multiplier engine between NREQ requesters.
- Each requester presents A/B operands with a valid/ready handshake.
- A round-robin arbiter grants one request at a time.
- The FSM sequences the engine for WIDTH iterations, then presents the product tagged with the requester index on a single response channel with backpressure.
- Sits between operand producers and the datapath multiplier slot.

Parameters:
NREQ, 4, number of requesters (>=2)
WIDTH, 4, operand width in bits; product is 2*WIDTH
IDW, $clog2(NREQ), requester index width (derived, localparam)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  input  NREQ  per-requester request valid
req_a  input  NREQ*WIDTH  packed multiplicands, requester i at [i*WIDTH +: WIDTH]
req_b  input  NREQ*WIDTH  packed multipliers, same packing
req_ready  output  NREQ  one-hot grant/accept strobe
rsp_valid  output  1  product available
rsp_id  output  IDW  index of requester owning rsp_product
rsp_product  output  2*WIDTH  unsigned A*B
rsp_ready  input  1  consumer accepts response
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, async), all outputs forced:
  - state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_product=0, busy=0.
  - last-grant pointer=NREQ-1, so requester 0 has top priority after reset.
- FSM states: IDLE -> COMPUTE -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational: one-hot on the winner when any req_valid=1, else all zero.
  - Winner: first i with req_valid[i]=1, scanning last+1, last+2, ... with modulo-NREQ wrap.
  - On the edge with a winner: capture a_reg, b_reg and id. Clear acc and iteration count. Set last=winner. Go to COMPUTE.
  - req_ready is 0 in every state except IDLE. Requests arriving in COMPUTE or RESP wait; the block never drops or queues them.
- COMPUTE, exactly WIDTH cycles; iteration k=0..WIDTH-1 per edge:
  - If b_reg[k]=1 then acc += a_reg << k.
  - acc is 2*WIDTH bits and cannot overflow.
  - After the edge completing k=WIDTH-1, go to RESP.
- RESP:
  - rsp_valid=1, rsp_product=acc and rsp_id=id are held stable until rsp_ready=1.
  - On the edge with rsp_valid&rsp_ready, go to IDLE; rsp_valid falls.
  - A new grant is possible on the following cycle; no IDLE->accept in the same cycle as the response handshake.
- Latency:
  - Accept edge E0 to rsp_valid visible after edge E0+WIDTH (4 cycles at default).
  - Minimum initiation interval is WIDTH+2 cycles.
- Boundary conditions:
  - Operand 0 gives product 0, still taking the full WIDTH cycles (no early exit).
  - Max operands: (2^WIDTH-1)^2.
  - All requesters valid every cycle: strict rotation 0,1,...,NREQ-1,0,...
  - Only the last-granted requester valid: it is granted again (no idle gap beyond protocol).
  - A requester deasserting req_valid before grant is legal; it is simply not chosen.
- Reset mid-operation (COMPUTE or RESP): the in-flight operation is discarded, with no response produced. Outputs return to reset values immediately (async), and the pointer is reset.
- rsp_ready high while not in RESP has no effect.

Decomposition:
- Shared package mult_pkg holds:
  - the state enum (IDLE, COMPUTE, RESP) and its encoding width;
  - the default WIDTH and NREQ constants;
  - a function rr_pick(valid, last) returning the winner index.
- One natural sub-module, mult_shift_add_core:
  - inputs: start, a, b;
  - outputs: done (1-cycle pulse) and product;
  - an iteration counter plus accumulator.
- The top module keeps the arbiter, FSM and response register.

Test Plan:
1. Single requester 0, A=2, B=2, rsp_ready=1 -> req_ready[0] pulses once; rsp_valid 4 cycles after accept; rsp_product=8'd4, rsp_id=0; busy high for 5 cycles.
2. Requester 2, A=5, B=3 -> rsp_product=15, rsp_id=2. Repeat with A=15, B=15 -> 225; A=0, B=9 -> 0 with the same 4-cycle latency.
3. All four requesters valid continuously, with operands (1,1), (2,3), (4,4), (7,5) -> grants in order 0,1,2,3,0; responses 1, 6, 16, 35 with matching rsp_id.
4. rsp_ready held 0 for 6 cycles in RESP -> rsp_valid, rsp_product and rsp_id stable; all req_ready=0; completes on the first rsp_ready=1 edge.
5. Assert reset mid-COMPUTE (cycle 2 of 4) -> rsp_valid, busy and req_ready go 0 without a clock; after release, requester 0 wins over requester 3 when both are valid.
6. Requester 1 valid alone after a grant to 1 -> re-granted on the first IDLE cycle; a requester dropping req_valid while the block is busy -> never granted.
